// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  // Transaction sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Owner encoding; also used for the round-robin "last owner" memory.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the memory-side bus of the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch requester
  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic              IGnt;
  logic              IDone;
  // Load/store requester
  logic              DReq;
  logic              DWe;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWData;
  logic              DGnt;
  logic              DDone;
  // Control and status
  logic              Hold;
  logic              Busy;
  logic [DATA_W-1:0] RData;
  // Memory side
  logic [ADDR_W-1:0] MemAddr;
  logic              MemWrite;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;

  // Arbiter view.
  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWData, Hold, MemRData,
    output IGnt, IDone, DGnt, DDone, Busy, RData, MemAddr, MemWrite, MemWData
  );

  // Requester / memory-model view.
  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWData, Hold, MemRData,
    input  IGnt, IDone, DGnt, DDone, Busy, RData, MemAddr, MemWrite, MemWData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// fetch path (I) and the load/store path (D). Every output is a flop.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int              CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;   // current owner, doubles as LastOwner
  logic              write_q, write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              winner_s;

  logic ignt_q, ignt_d;
  logic idone_q, idone_d;
  logic dgnt_q, dgnt_d;
  logic ddone_q, ddone_d;
  logic memwrite_q, memwrite_d;
  logic busy_q, busy_d;

  // Round-robin pick: a lone requester wins, a tie goes to the non-last owner.
  always_comb begin
    winner_s = OWN_I;
    if (bus.IReq && bus.DReq) begin
      winner_s = ~owner_q;
    end else if (bus.DReq) begin
      winner_s = OWN_D;
    end else begin
      winner_s = OWN_I;
    end
  end

  // Next-state and datapath: grant latches the request, WAIT counts latency.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (!bus.Hold && (bus.IReq || bus.DReq)) begin
          state_d = ISSUE;
          owner_d = winner_s;
          addr_d  = (winner_s == OWN_D) ? bus.DAddr : bus.IAddr;
          wdata_d = bus.DWData;
          write_d = bus.DWe & (winner_s == OWN_D);
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = bus.MemRData;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the flopped outputs track the state.
  always_comb begin
    busy_d     = (state_d != IDLE);
    ignt_d     = busy_d && (owner_d == OWN_I);
    dgnt_d     = busy_d && (owner_d == OWN_D);
    idone_d    = (state_d == DONE) && (owner_d == OWN_I);
    ddone_d    = (state_d == DONE) && (owner_d == OWN_D);
    memwrite_d = (state_d == ISSUE) && write_d;
  end

  // State and datapath registers; fetch wins the first tie after reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      owner_q <= OWN_D;
      write_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Handshake and status output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ignt_q     <= 1'b0;
      idone_q    <= 1'b0;
      dgnt_q     <= 1'b0;
      ddone_q    <= 1'b0;
      memwrite_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ignt_q     <= ignt_d;
      idone_q    <= idone_d;
      dgnt_q     <= dgnt_d;
      ddone_q    <= ddone_d;
      memwrite_q <= memwrite_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.IGnt     = ignt_q;
  assign bus.IDone    = idone_q;
  assign bus.DGnt     = dgnt_q;
  assign bus.DDone    = ddone_q;
  assign bus.MemWrite = memwrite_q;
  assign bus.Busy     = busy_q;
  assign bus.MemAddr  = addr_q;
  assign bus.MemWData = wdata_q;
  assign bus.RData    = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the
// RD_LAT=2 instance plus hand sequences for reset and an RD_LAT=1 build.
module tb_mem_port_arbiter;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.slave)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(bus1.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [31:0] J = 32'hBAD0_0BAD;
  // {IGnt, IDone, DGnt, DDone, MemWrite, Busy}
  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_IG   = 6'b100001;
  localparam logic [5:0] C_ID   = 6'b110001;
  localparam logic [5:0] C_DG   = 6'b001001;
  localparam logic [5:0] C_DW   = 6'b001011;
  localparam logic [5:0] C_DD   = 6'b001101;

  typedef struct {
    logic [3:0]  inb;     // {IReq, DReq, DWe, Hold}
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrd;
    logic [5:0]  ctl;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] inb, input logic [31:0] ia,
                              input logic [31:0] da, input logic [31:0] dw,
                              input logic [31:0] mrd, input logic [5:0] ctl,
                              input logic [31:0] ma, input logic [31:0] mw,
                              input logic [31:0] rd);
    vec_t v;
    v.inb = inb; v.iaddr = ia; v.daddr = da; v.dwdata = dw; v.mrd = mrd;
    v.ctl = ctl; v.maddr = ma; v.mwdata = mw; v.rdata = rd;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Grants and dones must never be asserted to both requesters at once.
  always @(negedge Clk) begin
    checks++;
    if ((bus.IGnt && bus.DGnt) || (bus.IDone && bus.DDone) ||
        (bus1.IGnt && bus1.DGnt) || (bus1.IDone && bus1.DDone)) begin
      errors++;
      $display("FAIL exclusive_gnt_done: got both asserted expected one-hot at %0t", $time);
    end
  end

  initial begin
    vec_t v;
    // Single fetch, address changes after grant are ignored.
    vq.push_back(mk(4'b1000, 32'h40, 32'h0, 32'h1111_1111, J, C_IDLE, 32'h0, 32'h0, 32'h0));
    vq.push_back(mk(4'b1000, 32'h44, 32'h0, 32'h1111_1111, J, C_IG, 32'h40, 32'h1111_1111, 32'h0));
    vq.push_back(mk(4'b1000, 32'h44, 32'h0, 32'h1111_1111, J, C_IG, 32'h40, 32'h1111_1111, 32'h0));
    vq.push_back(mk(4'b1000, 32'h44, 32'h0, 32'h1111_1111, 32'hDEAD_BEEF, C_IG, 32'h40, 32'h1111_1111, 32'h0));
    vq.push_back(mk(4'b0000, 32'h44, 32'h0, 32'h1111_1111, J, C_ID, 32'h40, 32'h1111_1111, 32'hDEAD_BEEF));
    // Store; DWe/DAddr/DWData changing after grant are ignored.
    vq.push_back(mk(4'b0110, 32'h44, 32'h100, 32'h1234_5678, J, C_IDLE, 32'h40, 32'h1111_1111, 32'hDEAD_BEEF));
    vq.push_back(mk(4'b0100, 32'h44, 32'h200, 32'hFFFF_FFFF, J, C_DW, 32'h100, 32'h1234_5678, 32'hDEAD_BEEF));
    vq.push_back(mk(4'b0000, 32'h44, 32'h200, 32'hFFFF_FFFF, J, C_DD, 32'h100, 32'h1234_5678, 32'hDEAD_BEEF));
    // Both held: I, D, I alternate with one IDLE cycle between.
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IDLE, 32'h100, 32'h1234_5678, 32'hDEAD_BEEF));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IG, 32'h80, 32'hA5A5_A5A5, 32'hDEAD_BEEF));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IG, 32'h80, 32'hA5A5_A5A5, 32'hDEAD_BEEF));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, 32'h0000_1111, C_IG, 32'h80, 32'hA5A5_A5A5, 32'hDEAD_BEEF));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_ID, 32'h80, 32'hA5A5_A5A5, 32'h0000_1111));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IDLE, 32'h80, 32'hA5A5_A5A5, 32'h0000_1111));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_DG, 32'h180, 32'hA5A5_A5A5, 32'h0000_1111));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_DG, 32'h180, 32'hA5A5_A5A5, 32'h0000_1111));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, 32'h2222_2222, C_DG, 32'h180, 32'hA5A5_A5A5, 32'h0000_1111));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_DD, 32'h180, 32'hA5A5_A5A5, 32'h2222_2222));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IDLE, 32'h180, 32'hA5A5_A5A5, 32'h2222_2222));
    vq.push_back(mk(4'b1100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IG, 32'h80, 32'hA5A5_A5A5, 32'h2222_2222));
    // Hold raised during WAIT of the fetch, DReq pending.
    vq.push_back(mk(4'b1101, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IG, 32'h80, 32'hA5A5_A5A5, 32'h2222_2222));
    vq.push_back(mk(4'b1101, 32'h80, 32'h180, 32'hA5A5_A5A5, 32'h3333_3333, C_IG, 32'h80, 32'hA5A5_A5A5, 32'h2222_2222));
    vq.push_back(mk(4'b0101, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_ID, 32'h80, 32'hA5A5_A5A5, 32'h3333_3333));
    vq.push_back(mk(4'b0101, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IDLE, 32'h80, 32'hA5A5_A5A5, 32'h3333_3333));
    vq.push_back(mk(4'b0101, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IDLE, 32'h80, 32'hA5A5_A5A5, 32'h3333_3333));
    vq.push_back(mk(4'b0100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IDLE, 32'h80, 32'hA5A5_A5A5, 32'h3333_3333));
    // D grant after Hold drops; request dropped mid-transaction still completes.
    vq.push_back(mk(4'b0100, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_DG, 32'h180, 32'hA5A5_A5A5, 32'h3333_3333));
    vq.push_back(mk(4'b0000, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_DG, 32'h180, 32'hA5A5_A5A5, 32'h3333_3333));
    vq.push_back(mk(4'b0000, 32'h80, 32'h180, 32'hA5A5_A5A5, 32'h4444_4444, C_DG, 32'h180, 32'hA5A5_A5A5, 32'h3333_3333));
    vq.push_back(mk(4'b0000, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_DD, 32'h180, 32'hA5A5_A5A5, 32'h4444_4444));
    vq.push_back(mk(4'b0000, 32'h80, 32'h180, 32'hA5A5_A5A5, J, C_IDLE, 32'h180, 32'hA5A5_A5A5, 32'h4444_4444));

    // Quiet inputs and reset.
    Reset = 1'b0;
    bus.IReq = 1'b0;  bus.IAddr = 32'h0;  bus.DReq = 1'b0;  bus.DWe = 1'b0;
    bus.DAddr = 32'h0; bus.DWData = 32'h0; bus.Hold = 1'b0;  bus.MemRData = J;
    bus1.IReq = 1'b0; bus1.IAddr = 32'h0; bus1.DReq = 1'b0; bus1.DWe = 1'b0;
    bus1.DAddr = 32'h0; bus1.DWData = 32'h0; bus1.Hold = 1'b0; bus1.MemRData = J;
    #3;
    chk1("reset_busy", bus.Busy, 1'b0);
    chk1("reset_ignt", bus.IGnt, 1'b0);
    chk1("reset_dgnt", bus.DGnt, 1'b0);
    chk1("reset_memwrite", bus.MemWrite, 1'b0);
    chk32("reset_rdata", bus.RData, 32'h0);
    chk32("reset_memaddr", bus.MemAddr, 32'h0);
    @(posedge Clk);
    tick();
    Reset = 1'b1;

    // Table-driven part.
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      bus.IReq = v.inb[3]; bus.DReq = v.inb[2]; bus.DWe = v.inb[1]; bus.Hold = v.inb[0];
      bus.IAddr = v.iaddr; bus.DAddr = v.daddr; bus.DWData = v.dwdata; bus.MemRData = v.mrd;
      chk1($sformatf("r%0d_ignt", i), bus.IGnt, v.ctl[5]);
      chk1($sformatf("r%0d_idone", i), bus.IDone, v.ctl[4]);
      chk1($sformatf("r%0d_dgnt", i), bus.DGnt, v.ctl[3]);
      chk1($sformatf("r%0d_ddone", i), bus.DDone, v.ctl[2]);
      chk1($sformatf("r%0d_memwrite", i), bus.MemWrite, v.ctl[1]);
      chk1($sformatf("r%0d_busy", i), bus.Busy, v.ctl[0]);
      chk32($sformatf("r%0d_memaddr", i), bus.MemAddr, v.maddr);
      chk32($sformatf("r%0d_memwdata", i), bus.MemWData, v.mwdata);
      chk32($sformatf("r%0d_rdata", i), bus.RData, v.rdata);
      tick();
    end

    // Reset pulled low during WAIT of a load.
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h300; bus.MemRData = J;
    tick();
    tick();
    chk1("rstmid_pre_dgnt", bus.DGnt, 1'b1);
    chk1("rstmid_pre_busy", bus.Busy, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    chk1("rstmid_busy", bus.Busy, 1'b0);
    chk1("rstmid_dgnt", bus.DGnt, 1'b0);
    chk1("rstmid_memwrite", bus.MemWrite, 1'b0);
    chk32("rstmid_rdata", bus.RData, 32'h0);
    bus.DReq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("rstmid_no_ddone", bus.DDone, 1'b0);
      chk1("rstmid_held_busy", bus.Busy, 1'b0);
    end
    Reset = 1'b1;
    bus.IReq = 1'b1; bus.IAddr = 32'h500;
    chk1("post_rst_c0_ignt", bus.IGnt, 1'b0);
    tick();
    chk1("post_rst_c1_ignt", bus.IGnt, 1'b1);
    chk32("post_rst_c1_memaddr", bus.MemAddr, 32'h500);
    tick();
    tick();
    bus.MemRData = 32'h6666_6666;
    chk1("post_rst_c3_idone", bus.IDone, 1'b0);
    tick();
    bus.MemRData = J;
    bus.IReq = 1'b0;
    chk1("post_rst_c4_idone", bus.IDone, 1'b1);
    chk1("post_rst_c4_ddone", bus.DDone, 1'b0);
    chk32("post_rst_c4_rdata", bus.RData, 32'h6666_6666);
    tick();
    chk1("post_rst_c5_busy", bus.Busy, 1'b0);

    // RD_LAT=1 build: first tie after reset goes to fetch, then one load.
    bus1.IReq = 1'b1; bus1.IAddr = 32'h70; bus1.DReq = 1'b1; bus1.DWe = 1'b0;
    bus1.DAddr = 32'h60; bus1.MemRData = J;
    chk1("l1_c0_busy", bus1.Busy, 1'b0);
    tick();
    chk1("l1_c1_ignt", bus1.IGnt, 1'b1);
    chk1("l1_c1_dgnt", bus1.DGnt, 1'b0);
    chk32("l1_c1_memaddr", bus1.MemAddr, 32'h70);
    tick();
    bus1.MemRData = 32'h7777_0001;
    chk1("l1_c2_idone", bus1.IDone, 1'b0);
    tick();
    bus1.MemRData = J;
    bus1.IReq = 1'b0;
    chk1("l1_c3_idone", bus1.IDone, 1'b1);
    chk32("l1_c3_rdata", bus1.RData, 32'h7777_0001);
    tick();
    chk1("l1_c4_busy", bus1.Busy, 1'b0);
    tick();
    chk1("l1_c5_dgnt", bus1.DGnt, 1'b1);
    chk32("l1_c5_memaddr", bus1.MemAddr, 32'h60);
    chk1("l1_c5_memwrite", bus1.MemWrite, 1'b0);
    tick();
    bus1.MemRData = 32'h5A5A_0002;
    chk1("l1_c6_ddone", bus1.DDone, 1'b0);
    tick();
    bus1.MemRData = J;
    bus1.DReq = 1'b0;
    chk1("l1_c7_ddone", bus1.DDone, 1'b1);
    chk32("l1_c7_rdata", bus1.RData, 32'h5A5A_0002);
    tick();
    chk1("l1_c8_ddone", bus1.DDone, 1'b0);
    chk1("l1_c8_busy", bus1.Busy, 1'b0);
    chk32("l1_c8_rdata", bus1.RData, 32'h5A5A_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
